// File: rtl/lector_contador.sv
// lector_contador: sweeps FIFO indices 0..FIFO_UNITS-1 over the req/idx
// query interface, captures each returned cuenta, then pulses done.
// A query left unanswered for TIMEOUT cycles aborts the sweep with a sticky error.
module lector_contador #(
    parameter int unsigned FIFO_UNITS = 4,
    parameter int unsigned INDEX      = 2,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             IDLE,
    input  logic [CNT_W-1:0] cuenta,
    input  logic             valid,
    output logic             req,
    output logic [INDEX-1:0] idx,
    output logic [CNT_W-1:0] cuenta_0,
    output logic [CNT_W-1:0] cuenta_1,
    output logic [CNT_W-1:0] cuenta_2,
    output logic [CNT_W-1:0] cuenta_3,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [INDEX-1:0] LAST_IDX = INDEX'(FIFO_UNITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [INDEX-1:0] idx_q,   idx_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;
    logic             err_q,   err_d;
    logic             req_q,   req_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [CNT_W-1:0] cnt_q [FIFO_UNITS];
    logic [CNT_W-1:0] cnt_d [FIFO_UNITS];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; IDLE only matters at accept, valid only in ST_WAIT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && IDLE) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (valid) begin
                    state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; strobes are decoded from the next state
    always_comb begin
        idx_d = idx_q;
        tmo_d = tmo_q;
        err_d = err_q;
        for (int i = 0; i < int'(FIFO_UNITS); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start && IDLE) begin
                    for (int i = 0; i < int'(FIFO_UNITS); i++) begin
                        cnt_d[i] = '0;
                    end
                    err_d = 1'b0;
                    idx_d = '0;
                end
            end
            ST_REQ: begin
                tmo_d = '0;
            end
            ST_WAIT: begin
                if (valid) begin
                    cnt_d[idx_q] = cuenta;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + INDEX'(1);
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_LAST) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            tmo_q  <= '0;
            err_q  <= 1'b0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_UNITS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            idx_q  <= idx_d;
            tmo_q  <= tmo_d;
            err_q  <= err_d;
            req_q  <= req_d;
            busy_q <= busy_d;
            done_q <= done_d;
            for (int i = 0; i < int'(FIFO_UNITS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign req      = req_q;
    assign idx      = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;
    assign cuenta_0 = cnt_q[0];
    assign cuenta_1 = cnt_q[1];
    assign cuenta_2 = cnt_q[2];
    assign cuenta_3 = cnt_q[3];

endmodule

// File: tb/tb_lector_contador.sv
// Scoreboard bench for lector_contador: stimulus pushes expected query
// indices and sweep results; monitors pop and compare on req and done.
module tb_lector_contador;

    localparam int unsigned F   = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned CW  = 5;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          IDLE;
    logic [CW-1:0] cuenta;
    logic          valid;
    logic          req;
    logic [IW-1:0] idx;
    logic [CW-1:0] cuenta_0, cuenta_1, cuenta_2, cuenta_3;
    logic          busy, done, error;

    lector_contador #(
        .FIFO_UNITS(F), .INDEX(IW), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .IDLE(IDLE),
        .cuenta(cuenta), .valid(valid), .req(req), .idx(idx),
        .cuenta_0(cuenta_0), .cuenta_1(cuenta_1), .cuenta_2(cuenta_2), .cuenta_3(cuenta_3),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c0, c1, c2, c3;
        int err;
        int t;
    } res_t;

    res_t exp_q[$];
    int   idx_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // responder controls
    logic [CW-1:0] resp [4];
    int            delay = 1;
    int            skip  = -1;
    bit            spur  = 1'b0;
    int            ri;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: answers each req after 'delay' cycles unless idx==skip
    always begin
        @(negedge clk);
        if (req && !reset) begin
            ri = int'(idx);
            if (spur) begin
                valid  = 1'b1;
                cuenta = 5'd21;
            end
            @(posedge clk);
            #1;
            valid = 1'b0;
            repeat (delay - 1) begin
                @(posedge clk);
                #1;
            end
            if (ri != skip && !reset) begin
                valid  = 1'b1;
                cuenta = resp[ri];
                @(posedge clk);
                #1;
                valid = 1'b0;
            end
        end
    end

    // Monitor: every req and every done is matched against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (req) begin
                if (idx_q.size() == 0) fail_now("unexpected_req");
                else chk("req_idx", int'(idx), idx_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("cuenta_0", int'(cuenta_0), e.c0);
                    chk("cuenta_1", int'(cuenta_1), e.c1);
                    chk("cuenta_2", int'(cuenta_2), e.c2);
                    chk("cuenta_3", int'(cuenta_3), e.c3);
                    chk("error", int'(error), e.err);
                    chk("done_cycle", cyc, e.t);
                end
            end
        end
    end

    // Issue an accepted start; push nreq query indices and optionally a result
    task automatic accept(input int nreq, input bit push, input res_t r, input int lat);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < nreq; i++) idx_q.push_back(i);
        if (push) begin
            r.t = cyc + lat;
            exp_q.push_back(r);
        end
        chk("accept_busy", int'(busy), 1);
        chk("accept_err_clr", int'(error), 0);
        chk("accept_cnt_clr", int'({cuenta_0, cuenta_1, cuenta_2, cuenta_3}), 0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_idle_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        bit   found;
        reset = 1'b1;
        start = 1'b0;
        IDLE  = 1'b1;
        valid = 1'b0;
        cuenta = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", int'(req), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_cnt", int'({cuenta_0, cuenta_1, cuenta_2, cuenta_3}), 0);
        reset = 1'b0;

        // 1: basic sweep, 1-cycle responder
        resp[0] = 5'd3; resp[1] = 5'd0; resp[2] = 5'd31; resp[3] = 5'd7;
        r = '{c0: 3, c1: 0, c2: 31, c3: 7, err: 0, t: 0};
        accept(4, 1'b1, r, 8);
        wait_idle();

        // 2: start while system not idle is ignored; counts hold
        IDLE = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("noidle_busy", int'(busy), 0);
            chk("noidle_req", int'(req), 0);
        end
        chk("hold_cuenta_2", int'(cuenta_2), 31);
        IDLE = 1'b1;
        resp[0] = 5'd1; resp[1] = 5'd2; resp[2] = 5'd4; resp[3] = 5'd8;
        r = '{c0: 1, c1: 2, c2: 4, c3: 8, err: 0, t: 0};
        accept(4, 1'b1, r, 8);
        wait_idle();

        // 3: no answer for idx 2 -> timeout abort
        skip = 2;
        resp[0] = 5'd10; resp[1] = 5'd11; resp[2] = 5'd12; resp[3] = 5'd13;
        r = '{c0: 10, c1: 11, c2: 0, c3: 0, err: 1, t: 0};
        accept(3, 1'b1, r, 13);
        wait_idle();
        chk("err_sticky", int'(error), 1);
        skip = -1;

        // 4: 3-cycle responder plus spurious valid during req
        delay = 3;
        spur  = 1'b1;
        resp[0] = 5'd17; resp[1] = 5'd5; resp[2] = 5'd30; resp[3] = 5'd1;
        r = '{c0: 17, c1: 5, c2: 30, c3: 1, err: 0, t: 0};
        accept(4, 1'b1, r, 16);
        wait_idle();
        delay = 1;
        spur  = 1'b0;

        // 5: reset during wait of idx 1 -> no done, everything cleared
        resp[0] = 5'd9; resp[1] = 5'd6; resp[2] = 5'd2; resp[3] = 5'd4;
        accept(2, 1'b0, r, 0);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req && idx == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("reset_test_no_req1");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_idx", int'(idx), 0);
        chk("midrst_req", int'(req), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cuenta_0", int'(cuenta_0), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_still_idle", int'(busy), 0);

        // 6: repeated start during sweep -> one sweep, one done
        resp[0] = 5'd25; resp[1] = 5'd14; resp[2] = 5'd8; resp[3] = 5'd19;
        r = '{c0: 25, c1: 14, c2: 8, c3: 19, err: 0, t: 0};
        accept(4, 1'b1, r, 8);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_idle();
        repeat (6) @(negedge clk);
        chk("final_busy", int'(busy), 0);
        chk("final_hold_cuenta_3", int'(cuenta_3), 19);
        chk("pending_idx", idx_q.size(), 0);
        chk("pending_results", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
